tail_light: RTL and testbench

//  Sequential turn-signal / hazard controller for a vehicle with three lamps per side.

---
 rtl/tail_light_pkg.sv | 26 ++
 rtl/tail_light_tick.sv | 28 ++
 rtl/tail_light.sv | 63 ++++++
 tb/tb_tail_light.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared types and lamp constants for the turn-signal / hazard controller.
package tail_light_pkg;

    typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ} state_t;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_ALL = 3'b111;

    // Returns {li, ri} for a state; lamps fill from the innermost (bit0) outward.
    function automatic logic [5:0] lamp_decode(input state_t s);
        logic [5:0] lamps;
        lamps = {LAMP_OFF, LAMP_OFF};
        case (s)
            L1:      lamps = {3'b001, LAMP_OFF};
            L2:      lamps = {3'b011, LAMP_OFF};
            L3:      lamps = {LAMP_ALL, LAMP_OFF};
            R1:      lamps = {LAMP_OFF, 3'b001};
            R2:      lamps = {LAMP_OFF, 3'b011};
            R3:      lamps = {LAMP_OFF, LAMP_ALL};
            HAZ:     lamps = {LAMP_ALL, LAMP_ALL};
            default: lamps = {LAMP_OFF, LAMP_OFF};
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/tail_light_tick.sv
// Step prescaler: free-running counter that pulses tick once every STEP_CYCLES clocks.
module tail_light_tick #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntLast);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tail_light.sv
// Turn-signal / hazard Moore FSM driving three lamps per side with registered outputs.
module tail_light
    import tail_light_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lt,
    input  logic       rt,
    input  logic       haz,
    output logic [2:0] li,
    output logic [2:0] ri
);

    state_t     state_q, state_d;
    logic [2:0] li_q, ri_q;
    logic       tick;

    tail_light_tick #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tick) begin
                if (haz || (lt && rt)) state_d = HAZ;
                else if (lt)           state_d = L1;
                else if (rt)           state_d = R1;
            end
            L1:   if (tick) state_d = haz ? HAZ : L2;
            L2:   if (tick) state_d = haz ? HAZ : L3;
            L3:   if (tick) state_d = haz ? HAZ : IDLE;
            R1:   if (tick) state_d = haz ? HAZ : R2;
            R2:   if (tick) state_d = haz ? HAZ : R3;
            R3:   if (tick) state_d = haz ? HAZ : IDLE;
            HAZ:  if (tick) state_d = IDLE;
            // Corrupted encodings return to IDLE without waiting for a tick.
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            li_q    <= LAMP_OFF;
            ri_q    <= LAMP_OFF;
        end else begin
            state_q      <= state_d;
            {li_q, ri_q} <= lamp_decode(state_d);
        end
    end

    assign li = li_q;
    assign ri = ri_q;

endmodule

// File: tb/tb_tail_light.sv
// Directed bench for tail_light at STEP_CYCLES=1 and STEP_CYCLES=4 sharing one stimulus.
module tb_tail_light;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lt  = 1'b0;
    logic       rt  = 1'b0;
    logic       haz = 1'b0;
    logic [2:0] li1, ri1, li4, ri4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    tail_light #(
        .STEP_CYCLES(1)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .lt (lt),
        .rt (rt),
        .haz(haz),
        .li (li1),
        .ri (ri1)
    );

    tail_light #(
        .STEP_CYCLES(4)
    ) u_dut4 (
        .clk(clk),
        .rst(rst),
        .lt (lt),
        .rt (rt),
        .haz(haz),
        .li (li4),
        .ri (ri4)
    );

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got li/ri=%b/%b, expected %b/%b",
                     tag, got[5:3], got[2:0], exp[5:3], exp[2:0]);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with release placed 1 time unit after an edge, so the prescaler starts at 0.
    task automatic do_reset();
        lt  = 1'b0;
        rt  = 1'b0;
        haz = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [2:0] pat [4];

    initial begin
        pat[0] = 3'b000;
        pat[1] = 3'b001;
        pat[2] = 3'b011;
        pat[3] = 3'b111;

        do_reset();
        check("reset_state", {li1, ri1}, 6'b000_000);
        check("reset_state4", {li4, ri4}, 6'b000_000);

        // Left held: 1-cycle DUT walks the pattern each clock, 4-cycle DUT every 4th clock.
        lt = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("left_seq k=%0d", k), {li1, ri1}, {pat[k % 4], 3'b000});
            check($sformatf("prescale k=%0d", k), {li4, ri4}, {pat[(k / 4) % 4], 3'b000});
        end

        // Async reset mid-L2 clears lamps without a clock edge.
        do_reset();
        lt = 1'b1;
        step();
        step();
        check("pre_reset_L2", {li1, ri1}, 6'b011_000);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", {li1, ri1}, 6'b000_000);
        step();
        lt  = 1'b0;
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("post_reset_idle k=%0d", k), {li1, ri1}, 6'b000_000);
        end

        // Right with early release still completes, then stays idle.
        do_reset();
        rt = 1'b1;
        step();
        check("right_r1", {li1, ri1}, 6'b000_001);
        rt = 1'b0;
        step();
        check("right_r2", {li1, ri1}, 6'b000_011);
        step();
        check("right_r3", {li1, ri1}, 6'b000_111);
        step();
        check("right_idle", {li1, ri1}, 6'b000_000);
        step();
        check("right_stay", {li1, ri1}, 6'b000_000);
        step();
        check("right_stay2", {li1, ri1}, 6'b000_000);

        // Sustained hazard alternates on/off.
        do_reset();
        haz = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("haz k=%0d", k), {li1, ri1}, (k % 2 == 1) ? 6'b111_111 : 6'b000_000);
        end
        haz = 1'b0;
        lt  = 1'b1;
        rt  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("lt_rt_haz k=%0d", k), {li1, ri1},
                  (k % 2 == 1) ? 6'b111_111 : 6'b000_000);
        end

        // Hazard arriving at L2 preempts the turn sequence.
        do_reset();
        lt = 1'b1;
        step();
        check("preempt_l1", {li1, ri1}, 6'b001_000);
        step();
        check("preempt_l2", {li1, ri1}, 6'b011_000);
        haz = 1'b1;
        step();
        check("preempt_haz", {li1, ri1}, 6'b111_111);
        haz = 1'b0;
        step();
        check("preempt_off", {li1, ri1}, 6'b000_000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
